// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 key event controller.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;
  localparam int unsigned EVT_W  = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_event_t;

endpackage

// File: rtl/ps2_key_event_ctrl_if.sv
// Valid/ready key event channel from the controller to its consumer.
interface ps2_key_event_ctrl_if;

  logic       key_valid;
  logic       key_ready;
  logic [7:0] key_code;
  logic       key_break;
  logic       key_ext;

  modport master (output key_valid, output key_code, output key_break,
                  output key_ext, input key_ready);
  modport slave  (input key_valid, input key_code, input key_break,
                  input key_ext, output key_ready);

endinterface

// File: rtl/ps2_event_fifo.sv
// Key event FIFO; a push into a full FIFO succeeds only if a pop happens in the same cycle.
module ps2_event_fifo #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned WIDTH      = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] dout,
  output logic             overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             full_c;
  logic             pop_c;
  logic             wr_c;

  assign full_c = (count == CW'(FIFO_DEPTH));
  assign valid  = (count != '0);
  assign dout   = mem[rd_ptr];
  assign pop_c  = valid && ready;
  assign wr_c   = push && (!full_c || pop_c);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem      <= '{default: '0};
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_c) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_c) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_c, pop_c})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      overflow <= push && full_c && !pop_c;
    end
  end

endmodule

// File: rtl/ps2_key_event_ctrl.sv
// PS/2 receiver: synchronizes the raw bus, frames bytes, folds E0/F0 prefixes
// into key events and queues them on a valid/ready channel.
module ps2_key_event_ctrl
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 200000,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ps2clk,
  input  logic                        data,
  ps2_key_event_ctrl_if.master        key_if,
  output logic [7:0]                  last_code,
  output logic                        par_err,
  output logic                        frame_err,
  output logic                        overflow
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  logic          clk_s1, clk_s2, clk_d;
  logic          dat_s1, dat_s2;
  logic          fall_c;

  ps2_state_e    state, state_n;
  logic [7:0]    shreg, shreg_n;
  logic [2:0]    bcnt, bcnt_n;
  logic          par_q, par_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic          perr_n, ferr_n;
  logic          bvld_q, bvld_n;

  logic          brk_q, ext_q;
  logic          push_c;
  ps2_event_t    evt_c;
  ps2_event_t    head;

  // Synchronizers reset high so the bus looks idle and no edge is seen on release.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_d  <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2clk;
      clk_s2 <= clk_s1;
      clk_d  <= clk_s2;
      dat_s1 <= data;
      dat_s2 <= dat_s1;
    end
  end

  assign fall_c = !clk_s2 && clk_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      bcnt      <= '0;
      par_q     <= 1'b0;
      tcnt      <= '0;
      par_err   <= 1'b0;
      frame_err <= 1'b0;
      bvld_q    <= 1'b0;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      bcnt      <= bcnt_n;
      par_q     <= par_n;
      tcnt      <= tcnt_n;
      par_err   <= perr_n;
      frame_err <= ferr_n;
      bvld_q    <= bvld_n;
    end
  end

  // Frame FSM; a stop bit fault outranks a parity fault.
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    bcnt_n  = bcnt;
    par_n   = par_q;
    tcnt_n  = tcnt;
    perr_n  = 1'b0;
    ferr_n  = 1'b0;
    bvld_n  = 1'b0;

    if (state == ST_IDLE || fall_c) tcnt_n = '0;
    else                            tcnt_n = tcnt + TW'(1);

    case (state)
      ST_IDLE: begin
        if (fall_c && !dat_s2) begin
          state_n = ST_DATA;
          bcnt_n  = '0;
        end
      end
      ST_DATA: begin
        if (fall_c) begin
          shreg_n = {dat_s2, shreg[7:1]};
          bcnt_n  = bcnt + 3'(1);
          if (bcnt == 3'd7) state_n = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (fall_c) begin
          par_n   = dat_s2;
          state_n = ST_STOP;
        end
      end
      ST_STOP: begin
        if (fall_c) begin
          if (!dat_s2)                 ferr_n = 1'b1;
          else if (!(^{shreg, par_q})) perr_n = 1'b1;
          else                         bvld_n = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (state != ST_IDLE && !fall_c && tcnt == TW'(TIMEOUT_CYC - 1)) begin
      state_n = ST_IDLE;
      ferr_n  = 1'b1;
      tcnt_n  = '0;
    end
  end

  // Prefix decoder: shreg still holds the delivered byte one cycle after the stop edge.
  assign push_c = bvld_q && (shreg != PS2_EXT) && (shreg != PS2_BRK);
  assign evt_c  = '{ext: ext_q, brk: brk_q, code: shreg};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      brk_q     <= 1'b0;
      ext_q     <= 1'b0;
      last_code <= '0;
    end else if (par_err || frame_err) begin
      brk_q <= 1'b0;
      ext_q <= 1'b0;
    end else if (bvld_q) begin
      if (shreg == PS2_EXT)      ext_q <= 1'b1;
      else if (shreg == PS2_BRK) brk_q <= 1'b1;
      else begin
        last_code <= shreg;
        brk_q     <= 1'b0;
        ext_q     <= 1'b0;
      end
    end
  end

  ps2_event_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (EVT_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push_c),
    .din      (evt_c),
    .ready    (key_if.key_ready),
    .valid    (key_if.key_valid),
    .dout     (head),
    .overflow (overflow)
  );

  assign key_if.key_code  = head.code;
  assign key_if.key_break = head.brk;
  assign key_if.key_ext   = head.ext;

endmodule

// File: doc/ps2_key_event_ctrl.md
PS2_KEY_EVENT_CTRL -- requirements
Module: ps2_key_event_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 200000, giving the CLK cycles without a PS2CLK falling edge before a partial frame is aborted.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, giving the number of key-event FIFO entries (power of two, at least 2).
REQ-003 CLK  input  1  system clock; all logic runs on its rising edge; the block uses one clock only.
REQ-004 RST_N  input  1  reset, synchronous and active-low.
REQ-005 PS2CLK  input  1  raw PS/2 clock, asynchronous to CLK.
REQ-006 DATA  input  1  raw PS/2 data, asynchronous to CLK.
REQ-007 KEY_READY  input  1  consumer accepts the head event.
REQ-008 KEY_VALID  output  1  the FIFO head event is valid.
REQ-009 KEY_CODE  output  8  head scan code; no prefix bytes.
REQ-010 KEY_BREAK  output  1  head event was preceded by F0 (key release).
REQ-011 KEY_EXT  output  1  head event was preceded by E0 (extended key).
REQ-012 LAST_CODE  output  8  most recent accepted non-prefix code, for the hex display.
REQ-013 PAR_ERR  output  1  one-cycle pulse on a parity failure.
REQ-014 FRAME_ERR  output  1  one-cycle pulse on a bad start/stop bit or a timeout.
REQ-015 OVERFLOW  output  1  one-cycle pulse when an event is dropped because the FIFO is full.

Function
REQ-016 SHALL pass PS2CLK and DATA through two-flop synchronizers; a falling edge is synchronized PS2CLK at 0 with its previous sample at 1.
REQ-017 SHALL sample synchronized DATA in the same CLK cycle that a falling edge is detected.
REQ-018 Frame FSM states: IDLE, DATA, PARITY, STOP.
- IDLE: edge with DATA=0 goes to DATA with bit count 0; edge with DATA=1 is ignored.
REQ-019 DATA: shift in 8 bits LSB first; after the 8th bit go to PARITY.
REQ-020 PARITY: capture the bit; the 9-bit set (data plus parity) SHALL have an odd number of ones; go to STOP.
REQ-021 STOP: edge with DATA=1 and good parity delivers the byte to the decoder.
- Parity bad: pulse PAR_ERR.
- DATA=0: pulse FRAME_ERR.
- If both faults occur, pulse FRAME_ERR only.
- In all cases return to IDLE.
REQ-022 In any non-IDLE state, TIMEOUT_CYC consecutive cycles without an edge SHALL return the FSM to IDLE and pulse FRAME_ERR; the timeout counter clears on every edge and while in IDLE.
REQ-023 Decoder behaviour for each delivered byte:
- E0 sets the ext flag.
- F0 sets the brk flag.
- Any other byte builds event {code, brk, ext}, updates LAST_CODE and clears both flags.
REQ-024 PAR_ERR or FRAME_ERR SHALL clear the brk and ext flags.
REQ-025 Each event SHALL be pushed into the FIFO in the cycle after the stop-bit edge is detected.
- KEY_VALID rises one cycle after the push when the FIFO was empty.
- Total latency is 2 CLK cycles from stop-edge detection.
REQ-026 Handshake:
- A pop occurs when KEY_VALID and KEY_READY are both high in a cycle.
- KEY_CODE, KEY_BREAK and KEY_EXT SHALL hold stable while KEY_VALID=1 and KEY_READY=0.
REQ-027 Push to a full FIFO with no pop in that cycle: drop the event, pulse OVERFLOW, keep the existing contents; flags and LAST_CODE update as normal.
REQ-028 Simultaneous push and pop: both SHALL succeed, including when the FIFO is full; no OVERFLOW.
REQ-029 FIFO pointers SHALL wrap modulo FIFO_DEPTH; an occupancy count of log2(FIFO_DEPTH)+1 bits distinguishes full from empty.

Reset
REQ-030 While RST_N=0 at a CLK edge, the block SHALL:
- set FSM=IDLE;
- clear the shift register, bit count, timeout counter, flags, FIFO pointers and occupancy;
- drive KEY_VALID=0, KEY_CODE=00, KEY_BREAK=0, KEY_EXT=0, LAST_CODE=00 and all pulses 0.
REQ-031 Reset asserted mid-frame SHALL discard the partial frame without an error pulse; the synchronizer flops SHALL reset to 1 so no false edge appears after reset.

Structure
REQ-032 Package ps2_pkg SHALL hold:
- the FSM state enum;
- constants PS2_EXT=8'hE0 and PS2_BRK=8'hF0;
- the 10-bit key-event record type {ext, brk, code[7:0]}.
REQ-033 The FIFO SHALL be one sub-module, ps2_event_fifo, parameterised by FIFO_DEPTH and the event width; everything else lives in ps2_key_event_ctrl.

Verification
REQ-034 Frame 1C (start 0, bits LSB first, parity 0, stop 1) -> KEY_VALID=1 exactly 2 cycles after stop-edge detection, KEY_CODE=1C, KEY_BREAK=0, KEY_EXT=0, LAST_CODE=1C.
REQ-035 Bytes E0, F0, 75 -> one event with KEY_CODE=75, KEY_BREAK=1, KEY_EXT=1; the next byte 1C gives BREAK=0, EXT=0.
REQ-036 Byte 1C with parity bit 1 -> PAR_ERR pulses once, no event is pushed, LAST_CODE is unchanged; F0 then a bad stop bit then 1C -> FRAME_ERR pulses and 1C arrives with BREAK=0.
REQ-037 KEY_READY=0 and 5 codes 01..05 with FIFO_DEPTH=4 -> OVERFLOW pulses on 05; pops then yield 01, 02, 03, 04 and KEY_VALID falls; pushing while full with KEY_READY=1 -> no OVERFLOW.
REQ-038 Stop PS2CLK after 4 data bits for TIMEOUT_CYC cycles -> FRAME_ERR pulses once, FSM returns to IDLE, the next full frame 2A decodes correctly; RST_N=0 mid-frame -> all outputs are at reset values and no error pulse occurs.
